// File: rtl/cacheline_arbiter.sv
// Two-requester arbiter sharing one physical-memory cacheline port between
// the instruction cache and the data cache, round-robin on contention.
module cacheline_arbiter #(
    parameter int s_line = 256,
    parameter int addr_w = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [addr_w-1:0] i_address,
    output logic [s_line-1:0] i_line_o,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [addr_w-1:0] d_address,
    input  logic [s_line-1:0] d_line_i,
    output logic [s_line-1:0] d_line_o,
    output logic              d_resp,

    output logic              mem_read,
    output logic              mem_write,
    output logic [addr_w-1:0] mem_address,
    output logic [s_line-1:0] mem_line_i,
    input  logic [s_line-1:0] mem_line_o,
    input  logic              mem_resp
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_I = 2'd1;
    localparam logic [1:0] SERVE_D = 2'd2;
    localparam logic [1:0] RECOVER = 2'd3;

    localparam logic PRIO_I = 1'b0;
    localparam logic PRIO_D = 1'b1;

    logic [1:0]        state;
    logic              prio;
    logic [addr_w-1:0] addr_q;
    logic [s_line-1:0] data_q;
    logic              rd_q;
    logic              wr_q;

    logic i_req;
    logic d_req;
    logic grant_i;
    logic grant_d;
    logic serving;

    assign i_req   = i_read;
    assign d_req   = d_read | d_write;
    assign grant_i = i_req & (~d_req | (prio == PRIO_I));
    assign grant_d = d_req & (~i_req | (prio == PRIO_D));
    assign serving = (state == SERVE_I) || (state == SERVE_D);

    // NOTE: every output is decoded from state, so the async reset forcing
    // state to IDLE drops the memory request and both resps without a clock.
    assign mem_read    = serving & rd_q;
    assign mem_write   = serving & wr_q;
    assign mem_address = serving ? addr_q : '0;
    assign mem_line_i  = serving ? data_q : '0;

    assign i_resp = (state == SERVE_I) & mem_resp;
    assign d_resp = (state == SERVE_D) & mem_resp;

    // Data is broadcast; only the resp tells a cache the line is meant for it.
    assign i_line_o = mem_line_o;
    assign d_line_o = mem_line_o;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            prio   <= PRIO_I;
            addr_q <= '0;
            data_q <= '0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        addr_q <= i_address;
                        rd_q   <= 1'b1;
                        wr_q   <= 1'b0;
                        state  <= SERVE_I;
                    end else if (grant_d) begin
                        // A simultaneous read+write is resolved as a writeback.
                        addr_q <= d_address;
                        data_q <= d_line_i;
                        rd_q   <= d_read & ~d_write;
                        wr_q   <= d_write;
                        state  <= SERVE_D;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (mem_resp) begin
                        prio  <= (state == SERVE_I) ? PRIO_D : PRIO_I;
                        state <= RECOVER;
                    end
                end
                RECOVER: state <= IDLE;
            endcase
        end
    end

    a_one_resp: assert property (@(posedge clk) disable iff (!rst)
        !(i_resp && d_resp));

    a_rw_excl: assert property (@(posedge clk) disable iff (!rst)
        !(mem_read && mem_write));

    a_addr_stable: assert property (@(posedge clk) disable iff (!rst)
        (serving && $past(serving)) |-> $stable(mem_address));

    a_d_protocol: assert property (@(posedge clk) disable iff (!rst)
        (state == IDLE) |-> !(d_read && d_write));

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed self-checking bench for cacheline_arbiter: single transfers,
// round-robin ties, input latching, stray responses and async reset.
module tb_cacheline_arbiter;

    localparam int S_LINE = 256;
    localparam int ADDR_W = 32;

    logic              clk;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [S_LINE-1:0] i_line_o;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [S_LINE-1:0] d_line_i;
    logic [S_LINE-1:0] d_line_o;
    logic              d_resp;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [S_LINE-1:0] mem_line_i;
    logic [S_LINE-1:0] mem_line_o;
    logic              mem_resp;

    int checks = 0;
    int errors = 0;

    logic [S_LINE-1:0] line_a5;
    logic [S_LINE-1:0] line_wb;
    logic [S_LINE-1:0] line_rd;

    cacheline_arbiter #(.s_line(S_LINE), .addr_w(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_read     (i_read),
        .i_address  (i_address),
        .i_line_o   (i_line_o),
        .i_resp     (i_resp),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_address  (d_address),
        .d_line_i   (d_line_i),
        .d_line_o   (d_line_o),
        .d_resp     (d_resp),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_address(mem_address),
        .mem_line_i (mem_line_i),
        .mem_line_o (mem_line_o),
        .mem_resp   (mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [S_LINE-1:0] obs,
                         input logic [S_LINE-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven 1 time unit after a rising edge and outputs checked
    // 1 unit later, well away from the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        line_a5 = {32{8'hA5}};
        line_wb = {8{32'h1234_5678}};
        line_rd = {8{32'hCAFE_F00D}};

        rst = 1'b0;
        i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_line_i = '0;
        mem_line_o = '0; mem_resp = 1'b0;

        #1;
        check("reset_mem_read",  mem_read,    1'b0);
        check("reset_mem_write", mem_write,   1'b0);
        check("reset_i_resp",    i_resp,      1'b0);
        check("reset_d_resp",    d_resp,      1'b0);
        check("reset_mem_addr",  mem_address, 32'h0);
        check("reset_mem_line",  mem_line_i,  256'h0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Single icache read, response 5 cycles after the grant.
        i_read = 1'b1; i_address = 32'h0000_1040;
        tick();
        #1;
        check("t1_mem_read",  mem_read,    1'b1);
        check("t1_mem_write", mem_write,   1'b0);
        check("t1_mem_addr",  mem_address, 32'h0000_1040);
        i_read = 1'b0; i_address = 32'hDEAD_BEEF;
        for (int k = 0; k < 4; k++) begin
            tick();
            #1;
            check("t1_hold_read", mem_read,    1'b1);
            check("t1_hold_addr", mem_address, 32'h0000_1040);
        end
        mem_line_o = line_a5; mem_resp = 1'b1;
        #1;
        check("t1_i_resp", i_resp,   1'b1);
        check("t1_i_line", i_line_o, line_a5);
        check("t1_d_resp", d_resp,   1'b0);
        tick();
        mem_resp = 1'b0;
        #1;
        check("t1_recover_read", mem_read, 1'b0);
        check("t1_recover_resp", i_resp,   1'b0);
        tick();

        // Dcache writeback.
        d_write = 1'b1; d_address = 32'h8000_0020; d_line_i = line_wb;
        tick();
        #1;
        check("t2_mem_write", mem_write,   1'b1);
        check("t2_mem_read",  mem_read,    1'b0);
        check("t2_mem_addr",  mem_address, 32'h8000_0020);
        check("t2_mem_data",  mem_line_i,  line_wb);
        d_write = 1'b0; d_line_i = '0;
        for (int k = 0; k < 2; k++) begin
            tick();
            #1;
            check("t2_hold_write", mem_write,  1'b1);
            check("t2_hold_read",  mem_read,   1'b0);
            check("t2_hold_data",  mem_line_i, line_wb);
        end
        mem_resp = 1'b1;
        #1;
        check("t2_d_resp",    d_resp,   1'b1);
        check("t2_i_resp",    i_resp,   1'b0);
        check("t2_resp_read", mem_read, 1'b0);
        tick();
        mem_resp = 1'b0;
        #1;
        check("t2_recover_write", mem_write, 1'b0);
        tick();

        // Simultaneous requests right out of reset: icache first.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        i_read = 1'b1; i_address = 32'h400;
        d_read = 1'b1; d_address = 32'h300;
        tick();
        #1;
        check("t3_first_read", mem_read,    1'b1);
        check("t3_first_addr", mem_address, 32'h400);
        tick();
        tick();
        mem_resp = 1'b1; mem_line_o = line_rd;
        #1;
        check("t3_i_resp", i_resp, 1'b1);
        check("t3_d_resp", d_resp, 1'b0);
        tick();
        mem_resp = 1'b0;
        #1;
        check("t3_gap1_read", mem_read, 1'b0);
        tick();
        #1;
        check("t3_gap2_read", mem_read, 1'b0);
        // Both still requesting: the tie now goes to dcache.
        tick();
        #1;
        check("t3_second_read", mem_read,    1'b1);
        check("t3_second_addr", mem_address, 32'h300);
        mem_resp = 1'b1;
        #1;
        check("t3_d_resp2", d_resp,   1'b1);
        check("t3_d_line",  d_line_o, line_rd);
        check("t3_i_resp2", i_resp,   1'b0);
        tick();
        mem_resp = 1'b0; d_read = 1'b0;
        tick();
        tick();
        #1;
        check("t3_third_read", mem_read,    1'b1);
        check("t3_third_addr", mem_address, 32'h400);
        mem_resp = 1'b1;
        #1;
        check("t3_i_resp3", i_resp, 1'b1);
        tick();
        mem_resp = 1'b0; i_read = 1'b0;
        tick();

        // Requester changes its address mid-transaction.
        d_read = 1'b1; d_address = 32'h100;
        tick();
        #1;
        check("t4_read", mem_read,    1'b1);
        check("t4_addr", mem_address, 32'h100);
        d_address = 32'h200;
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            check("t4_hold_addr", mem_address, 32'h100);
        end
        mem_resp = 1'b1;
        #1;
        check("t4_resp_addr", mem_address, 32'h100);
        check("t4_d_resp",    d_resp,      1'b1);
        tick();
        mem_resp = 1'b0; d_read = 1'b0;
        tick();

        // Stray mem_resp in IDLE is ignored and the state stays IDLE.
        mem_resp = 1'b1;
        #1;
        check("t6_stray_i_resp", i_resp,   1'b0);
        check("t6_stray_d_resp", d_resp,   1'b0);
        check("t6_stray_read",   mem_read, 1'b0);
        tick();
        mem_resp = 1'b0;
        i_read = 1'b1; i_address = 32'h600;
        #1;
        check("t6_idle_read", mem_read, 1'b0);
        tick();
        #1;
        check("t6_grant_read", mem_read,    1'b1);
        check("t6_grant_addr", mem_address, 32'h600);
        mem_resp = 1'b1;
        #1;
        check("t6_i_resp", i_resp, 1'b1);
        tick();
        mem_resp = 1'b0; i_read = 1'b0;
        tick();

        // Async reset while serving the icache (priority currently dcache).
        i_read = 1'b1; i_address = 32'h700;
        tick();
        #1;
        check("t5_read", mem_read, 1'b1);
        mem_resp = 1'b1;
        #1;
        check("t5_pre_i_resp", i_resp, 1'b1);
        rst = 1'b0;
        #1;
        check("t5_async_read",   mem_read, 1'b0);
        check("t5_async_i_resp", i_resp,   1'b0);
        check("t5_async_d_resp", d_resp,   1'b0);
        check("t5_async_addr",   mem_address, 32'h0);
        mem_resp = 1'b0; i_read = 1'b0;
        tick();
        rst = 1'b1;
        i_read = 1'b1; i_address = 32'h800;
        d_read = 1'b1; d_address = 32'h900;
        tick();
        #1;
        check("t5_tie_read", mem_read,    1'b1);
        check("t5_tie_addr", mem_address, 32'h800);
        mem_resp = 1'b1;
        #1;
        check("t5_tie_i_resp", i_resp, 1'b1);
        tick();
        mem_resp = 1'b0; i_read = 1'b0; d_read = 1'b0;
        tick();
        tick();
        #1;
        check("t5_drain_read", mem_read, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
